jt10_adpcm_rdata: RTL and testbench
===================================

# jt10_adpcm_rdata

ADPCM-A sample read-data responder: consumes the slot-multiplexed ROM read stream (byte address, nibble select, read strobe) produced by the ADPCM address counter and returns the addressed 4-bit sample nibble per channel slot. Holds a one-byte prefetch buffer per channel (6 channels) and fetches bytes from the external sample memory through a req/ok handshake. Sits between the ADPCM address counter and the ADPCM-A nibble decoder.

## Interface
Parameters:
- CH, 6, number of time-multiplexed channel slots (slot index 3 bits)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- cen  in  1  clock enable; one channel slot per cen
- slot_sync  in  1  marks slot 0 on the current cen
- addr_in  in  20  byte address for current slot
- sel_in  in  1  nibble select: 0 = bits [7:4], 1 = bits [3:0]
- roe_n  in  1  read strobe for current slot, active low
- rom_addr  out  20  sample memory byte address
- rom_req  out  1  memory request, held until rom_ok
- rom_data  in  8  memory read data, valid with rom_ok
- rom_ok  in  1  memory acknowledge, one-clk pulse
- nibble  out  4  sample nibble
- nibble_vld  out  1  nibble valid
- nibble_ch  out  3  slot of nibble
- underrun  out  1  one-cen pulse: read of a byte not yet fetched

## Operation
- Slot counter s: on cen, s <= slot_sync ? 0 : (s==CH-1 ? 0 : s+1). Slot logic uses s (or 0 when slot_sync).
- Per channel c: tag[c] (20b), data[c] (8b), valid[c], pend[c].
- Slot logic, on cen, current slot c:
  - roe_n=1: nibble_vld<=0, underrun<=0, channel state untouched.
  - roe_n=0, valid[c] and tag[c]==addr_in (hit): nibble<=sel_in ? data[c][3:0] : data[c][7:4]; nibble_vld<=1. If sel_in=1: prefetch, tag[c]<=addr_in+1 (20-bit wrap, 0xFFFFF -> 0x00000), valid[c]<=0, pend[c]<=1.
  - roe_n=0, tag[c]!=addr_in (miss): nibble_vld<=0, underrun<=1, tag[c]<=addr_in, valid[c]<=0, pend[c]<=1.
  - roe_n=0, tag match, !valid[c] (in flight): nibble_vld<=0, underrun<=1, state untouched.
  - nibble_ch<=c on every cen.
- Fetch FSM (runs every clk, not gated by cen):
  - IDLE: if any pend, cur<=lowest pending index, rom_addr<=tag[cur], rom_req<=1, stale<=0 -> REQ.
  - REQ: if slot logic retags cur this clk, stale<=1. On rom_ok: rom_req<=0 -> IDLE; if neither stale nor retag in same clk: data[cur]<=rom_data, valid[cur]<=1, pend[cur]<=0; else data discarded, pend[cur] stays 1 (refetched with new tag).
  - rom_ok in IDLE ignored. rom_addr stable while rom_req=1.
- Reset: s=0, all tag/data=0, valid=pend=0, FSM IDLE, stale=0, rom_req=0, rom_addr=0, nibble=0, nibble_vld=0, nibble_ch=0, underrun=0. Reset during REQ drops rom_req next clk; memory side must tolerate the abandoned request.

## Timing
- Slot outputs registered on the cen edge that samples the slot: 1 cen latency.
- pend set at edge N -> rom_req high at edge N+1 (IDLE decision). rom_ok sampled at edge M -> valid[cur] high and rom_req low after edge M; a hit is possible on the next cen.
- Minimum pend-to-valid: 2 clk with rom_ok asserted immediately.
- One request outstanding at a time; fixed priority, lowest channel first.
- Channel revisit is ≥ CH cen; with memory latency ≤ CH-2 clk at cen=1, every sel=1 prefetch completes before the next sel=0 read (no underrun in steady state).

## Test plan
- Reset: assert rst 2 clk with stimulus active -> all outputs 0, rom_req=0; first cen after release gives nibble_ch=0.
- Cold miss then hit: slot 2, addr 0x00100, sel 0 -> underrun=1, nibble_vld=0, rom_req with rom_addr=0x00100; rom_ok data 0xA5 after 3 clk; next slot-2 read addr 0x00100 sel 0 -> nibble=0xA, nibble_ch=2; sel 1 -> nibble=0x5 and rom_addr=0x00101 requested.
- Wrap: channel hit at addr 0xFFFFF sel 1 -> prefetch rom_addr=0x00000.
- Arbitration: misses on ch 4 and ch 1 pending while FSM busy -> ch 1 fetched before ch 4.
- Stale: ch 3 retagged 0x00200 -> 0x00300 while its request is in REQ; rom_ok data 0x11 -> discarded, new request rom_addr=0x00300, data 0x77 -> later read sel 0 gives 0x7.
- slot_sync mid-round at s=3 -> nibble_ch=0 next; roe_n=1 slots -> nibble_vld=0, underrun=0, no requests.

Source files
------------

// File: rtl/jt10_adpcm_rdata_if.sv
// Sample-memory read port: the responder drives address/request, memory returns data/ack.
interface jt10_adpcm_rdata_if;
  logic [19:0] rom_addr;
  logic        rom_req;
  logic [7:0]  rom_data;
  logic        rom_ok;

  modport master (
    output rom_addr,
    output rom_req,
    input  rom_data,
    input  rom_ok
  );

  modport slave (
    input  rom_addr,
    input  rom_req,
    output rom_data,
    output rom_ok
  );
endinterface

// File: rtl/jt10_adpcm_rdata.sv
// ADPCM-A read-data responder: per-channel one-byte prefetch buffer in front of the sample
// memory, answering slot-multiplexed nibble reads and fetching bytes one request at a time.
module jt10_adpcm_rdata #(
  parameter int unsigned CH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               slot_sync,
  input  logic [19:0]        addr_in,
  input  logic               sel_in,
  input  logic               roe_n,
  jt10_adpcm_rdata_if.master rom,
  output logic [3:0]         nibble,
  output logic               nibble_vld,
  output logic [2:0]         nibble_ch,
  output logic               underrun
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  // Slot counter and per-channel buffer state
  logic [2:0]    s_q, s_d, slot;
  logic [19:0]   tag_q  [CH];
  logic [19:0]   tag_d  [CH];
  logic [7:0]    data_q [CH];
  logic [7:0]    data_d [CH];
  logic [CH-1:0] valid_q, valid_d;
  logic [CH-1:0] pend_q, pend_d;

  // Fetch engine
  state_e        state_q, state_d;
  logic [2:0]    cur_q, cur_d, low_pend;
  logic          stale_q, stale_d;
  logic [19:0]   rom_addr_q, rom_addr_d;
  logic          rom_req, any_pend, fill;

  // Slot outputs
  logic [3:0]    nibble_q, nibble_d;
  logic          nibble_vld_q, nibble_vld_d;
  logic [2:0]    nibble_ch_q, nibble_ch_d;
  logic          underrun_q, underrun_d;

  // Slot-access decode
  logic          rd, tag_match, hit, retag;
  logic [19:0]   new_tag;

  assign slot      = slot_sync ? 3'd0 : s_q;
  assign rd        = cen && !roe_n;
  assign tag_match = (tag_q[slot] == addr_in);
  assign hit       = tag_match && valid_q[slot];
  // A miss retags to the requested byte; a low-nibble hit retags to the following byte.
  assign retag     = rd && (!tag_match || (hit && sel_in));
  assign new_tag   = tag_match ? addr_in + 20'd1 : addr_in;
  assign any_pend  = |pend_q;

  always_comb begin
    low_pend = '0;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (pend_q[i]) low_pend = 3'(i);
    end
  end

  // Slot counter and registered slot outputs
  always_comb begin
    s_d          = s_q;
    nibble_d     = nibble_q;
    nibble_vld_d = nibble_vld_q;
    nibble_ch_d  = nibble_ch_q;
    underrun_d   = underrun_q;
    if (cen) begin
      s_d          = (slot_sync || s_q == 3'(CH - 1)) ? 3'd0 : s_q + 3'd1;
      nibble_ch_d  = slot;
      nibble_vld_d = 1'b0;
      underrun_d   = 1'b0;
      if (!roe_n) begin
        if (hit) begin
          nibble_d     = sel_in ? data_q[slot][3:0] : data_q[slot][7:4];
          nibble_vld_d = 1'b1;
        end else begin
          underrun_d   = 1'b1;
        end
      end
    end
  end

  // Channel state: a retag from the slot side overrides a fill of the same channel
  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    if (fill) begin
      data_d[cur_q]  = rom.rom_data;
      valid_d[cur_q] = 1'b1;
      pend_d[cur_q]  = 1'b0;
    end
    if (retag) begin
      tag_d[slot]   = new_tag;
      valid_d[slot] = 1'b0;
      pend_d[slot]  = 1'b1;
    end
  end

  // Fetch FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_pend) state_d = StReq;
      StReq:   if (rom.rom_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Fetch FSM: outputs and datapath
  always_comb begin
    cur_d      = cur_q;
    rom_addr_d = rom_addr_q;
    stale_d    = stale_q;
    fill       = 1'b0;
    rom_req    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_pend) begin
          cur_d      = low_pend;
          rom_addr_d = tag_q[low_pend];
          // The chosen channel may be retagged on the very clk its address is latched.
          stale_d    = retag && (slot == low_pend);
        end
      end
      StReq: begin
        rom_req = 1'b1;
        stale_d = stale_q || (retag && (slot == cur_q));
        fill    = rom.rom_ok && !stale_q && !(retag && (slot == cur_q));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q          <= '0;
      tag_q        <= '{default: '0};
      data_q       <= '{default: '0};
      valid_q      <= '0;
      pend_q       <= '0;
      state_q      <= StIdle;
      cur_q        <= '0;
      stale_q      <= 1'b0;
      rom_addr_q   <= '0;
      nibble_q     <= '0;
      nibble_vld_q <= 1'b0;
      nibble_ch_q  <= '0;
      underrun_q   <= 1'b0;
    end else begin
      s_q          <= s_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      pend_q       <= pend_d;
      state_q      <= state_d;
      cur_q        <= cur_d;
      stale_q      <= stale_d;
      rom_addr_q   <= rom_addr_d;
      nibble_q     <= nibble_d;
      nibble_vld_q <= nibble_vld_d;
      nibble_ch_q  <= nibble_ch_d;
      underrun_q   <= underrun_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign rom.rom_req  = rom_req;
  assign nibble       = nibble_q;
  assign nibble_vld   = nibble_vld_q;
  assign nibble_ch    = nibble_ch_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_jt10_adpcm_rdata.sv
// Directed vector bench for jt10_adpcm_rdata: one table row per clock, memory responses in-row.
module tb_jt10_adpcm_rdata;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        slot_sync;
  logic [19:0] addr_in;
  logic        sel_in;
  logic        roe_n;
  logic [3:0]  nibble;
  logic        nibble_vld;
  logic [2:0]  nibble_ch;
  logic        underrun;

  jt10_adpcm_rdata_if rom_if ();

  jt10_adpcm_rdata #(.CH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .slot_sync  (slot_sync),
    .addr_in    (addr_in),
    .sel_in     (sel_in),
    .roe_n      (roe_n),
    .rom        (rom_if.master),
    .nibble     (nibble),
    .nibble_vld (nibble_vld),
    .nibble_ch  (nibble_ch),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cen;
    logic        sync;
    logic        roe_n;
    logic [19:0] addr;
    logic        sel;
    logic        ok;
    logic [7:0]  rdata;
    logic        vld;
    logic [3:0]  nib;
    logic [2:0]  ch;
    logic        und;
    logic        req;
    logic [19:0] raddr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic c, input logic sy, input logic ro, input logic [19:0] a,
                              input logic se, input logic ok, input logic [7:0] rd,
                              input logic vl, input logic [3:0] nb, input logic [2:0] ch,
                              input logic un, input logic rq, input logic [19:0] ra);
    vec_t v;
    v.cen = c;  v.sync = sy; v.roe_n = ro; v.addr = a;  v.sel = se; v.ok = ok; v.rdata = rd;
    v.vld = vl; v.nib = nb;  v.ch = ch;    v.und = un;  v.req = rq; v.raddr = ra;
    return v;
  endfunction

  // Idle slot row: roe_n high, only slot number and request state expected
  function automatic vec_t idl(input logic [2:0] ch, input logic rq, input logic [19:0] ra);
    return mk(1, 0, 1, 20'h0, 0, 0, 8'h00, 0, 4'h0, ch, 0, rq, ra);
  endfunction

  // Memory acknowledge row on an idle slot
  function automatic vec_t ack(input logic [7:0] rd, input logic [2:0] ch);
    return mk(1, 0, 1, 20'h0, 0, 1, rd, 0, 4'h0, ch, 0, 0, 20'h0);
  endfunction

  task automatic apply(input vec_t v);
    cen             = v.cen;
    slot_sync       = v.sync;
    roe_n           = v.roe_n;
    addr_in         = v.addr;
    sel_in          = v.sel;
    rom_if.rom_ok   = v.ok;
    rom_if.rom_data = v.rdata;
    @(posedge clk);
    #1;
  endtask

  // strict also demands nibble and rom_addr values when not flagged valid (reset checks)
  task automatic check(input string name, input bit strict, input vec_t v);
    bit bad;
    n_vec++;
    bad = (nibble_vld !== v.vld) || (underrun !== v.und) || (nibble_ch !== v.ch) ||
          (rom_if.rom_req !== v.req) ||
          ((v.vld || strict) && nibble !== v.nib) ||
          ((v.req || strict) && rom_if.rom_addr !== v.raddr);
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got vld=%b nib=%h ch=%0d und=%b req=%b raddr=%h; want vld=%b nib=%h ch=%0d und=%b req=%b raddr=%h",
               name, nibble_vld, nibble, nibble_ch, underrun, rom_if.rom_req, rom_if.rom_addr,
               v.vld, v.nib, v.ch, v.und, v.req, v.raddr);
    end
  endtask

  initial begin
    vec_t zero;
    zero = mk(1, 0, 1, 20'h0, 0, 0, 8'h00, 0, 4'h0, 3'd0, 0, 0, 20'h0);

    // Cold miss on ch2, fill 0xA5, hits, prefetch of 0x00101 (rom_ok in IDLE on row 1 ignored)
    vecs.push_back(idl(0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 20'h0, 0, 1, 8'hEE, 0, 4'h0, 1, 0, 0, 20'h0));
    vecs.push_back(mk(1, 0, 0, 20'h00100, 0, 0, 8'h00, 0, 4'h0, 2, 1, 0, 20'h0));
    vecs.push_back(idl(3, 1, 20'h00100));
    vecs.push_back(idl(4, 1, 20'h00100));
    vecs.push_back(idl(5, 1, 20'h00100));
    vecs.push_back(ack(8'hA5, 0));
    vecs.push_back(idl(1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 20'h00100, 0, 0, 8'h00, 1, 4'hA, 2, 0, 0, 20'h0));
    for (int i = 0; i < 5; i++) vecs.push_back(idl(3'((3 + i) % 6), 0, 0));
    vecs.push_back(mk(1, 0, 0, 20'h00100, 1, 0, 8'h00, 1, 4'h5, 2, 0, 0, 20'h0));
    vecs.push_back(idl(3, 1, 20'h00101));
    vecs.push_back(ack(8'h3C, 4));
    vecs.push_back(idl(5, 0, 0));
    vecs.push_back(idl(0, 0, 0));
    vecs.push_back(idl(1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 20'h00101, 0, 0, 8'h00, 1, 4'h3, 2, 0, 0, 20'h0));
    // Address wrap on ch0
    vecs.push_back(idl(3, 0, 0));
    vecs.push_back(idl(4, 0, 0));
    vecs.push_back(idl(5, 0, 0));
    vecs.push_back(mk(1, 0, 0, 20'hFFFFF, 0, 0, 8'h00, 0, 4'h0, 0, 1, 0, 20'h0));
    vecs.push_back(idl(1, 1, 20'hFFFFF));
    vecs.push_back(ack(8'h96, 2));
    vecs.push_back(idl(3, 0, 0));
    vecs.push_back(idl(4, 0, 0));
    vecs.push_back(idl(5, 0, 0));
    vecs.push_back(mk(1, 0, 0, 20'hFFFFF, 1, 0, 8'h00, 1, 4'h6, 0, 0, 0, 20'h0));
    vecs.push_back(idl(1, 1, 20'h00000));
    vecs.push_back(ack(8'h42, 2));
    // Arbitration (ch3 busy, ch4 and ch1 queue) and stale retag of ch3 0x200 -> 0x300
    vecs.push_back(mk(1, 0, 0, 20'h00200, 0, 0, 8'h00, 0, 4'h0, 3, 1, 0, 20'h0));
    vecs.push_back(mk(1, 0, 0, 20'h00400, 0, 0, 8'h00, 0, 4'h0, 4, 1, 1, 20'h00200));
    vecs.push_back(idl(5, 1, 20'h00200));
    vecs.push_back(idl(0, 1, 20'h00200));
    vecs.push_back(mk(1, 0, 0, 20'h00110, 0, 0, 8'h00, 0, 4'h0, 1, 1, 1, 20'h00200));
    vecs.push_back(idl(2, 1, 20'h00200));
    vecs.push_back(mk(1, 0, 0, 20'h00300, 0, 0, 8'h00, 0, 4'h0, 3, 1, 1, 20'h00200));
    vecs.push_back(ack(8'h11, 4));
    vecs.push_back(idl(5, 1, 20'h00110));
    vecs.push_back(ack(8'hB7, 0));
    vecs.push_back(idl(1, 1, 20'h00300));
    vecs.push_back(ack(8'h77, 2));
    vecs.push_back(mk(1, 0, 0, 20'h00300, 0, 0, 8'h00, 1, 4'h7, 3, 0, 1, 20'h00400));
    vecs.push_back(mk(1, 0, 0, 20'h00400, 0, 0, 8'h00, 0, 4'h0, 4, 1, 1, 20'h00400));
    vecs.push_back(ack(8'hD2, 5));
    vecs.push_back(idl(0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 20'h00110, 1, 0, 8'h00, 1, 4'h7, 1, 0, 0, 20'h0));
    vecs.push_back(idl(2, 1, 20'h00111));
    vecs.push_back(ack(8'h00, 3));
    vecs.push_back(mk(1, 0, 0, 20'h00400, 0, 0, 8'h00, 1, 4'hD, 4, 0, 0, 20'h0));
    // slot_sync at s=3, then a cen-low clock that must change nothing
    for (int i = 0; i < 4; i++) vecs.push_back(idl(3'((5 + i) % 6), 0, 0));
    vecs.push_back(mk(1, 1, 1, 20'h0, 0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 20'h0));
    vecs.push_back(idl(0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 20'h00777, 0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 20'h0));
    vecs.push_back(idl(1, 0, 0));
    vecs.push_back(idl(2, 0, 0));

    // Reset held 2 clk with live stimulus
    rst             = 1'b1;
    cen             = 1'b1;
    slot_sync       = 1'b0;
    roe_n           = 1'b0;
    addr_in         = 20'h12345;
    sel_in          = 1'b1;
    rom_if.rom_ok   = 1'b1;
    rom_if.rom_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1, zero);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check($sformatf("row%0d", i), 0, vecs[i]);
    end

    // Reset while a request is outstanding
    apply(mk(1, 0, 0, 20'h00500, 0, 0, 8'h00, 0, 4'h0, 3, 1, 0, 20'h0));
    check("rst_req_miss", 0, mk(1, 0, 0, 20'h00500, 0, 0, 8'h00, 0, 4'h0, 3, 1, 0, 20'h0));
    apply(idl(4, 1, 20'h00500));
    check("rst_req_up", 0, idl(4, 1, 20'h00500));
    rst = 1'b1;
    apply(idl(0, 0, 0));
    check("rst_req_drop", 1, zero);
    rst = 1'b0;
    apply(idl(0, 0, 0));
    check("rst_first_slot", 0, idl(0, 0, 0));
    apply(idl(1, 0, 0));
    check("rst_no_refetch", 0, idl(1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
